rrat_commit_unit: RTL

Parametrised retirement register alias table with multi-lane commit. It keeps the committed architectural-to-physical mapping for all GPRs plus NZCV. Overwritten physical registers are buffered in a free queue and drained to the free register list (FRL) through a valid/ready handshake. On pipeline recovery it streams the committed map back to the speculative RAT over a fixed number of cycles.

---
 rtl/rrat_commit_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rrat_commit_unit.sv
// rrat_commit_unit: retirement RAT with multi-lane commit, free-reg queue to the FRL,
// and beat-wise streaming of the committed map on recovery.  Rev 1.0
`default_nettype none

module rrat_commit_unit #(
    parameter int NUM_PHYS_REGS  = 128,
    parameter int NUM_ARCH_REGS  = 32,
    parameter int COMMIT_WIDTH   = 4,
    parameter int FREE_Q_DEPTH   = 16,
    parameter int FREE_OUT_WIDTH = 2,
    parameter int RECOVER_WIDTH  = 4,
    localparam int PW = $clog2(NUM_PHYS_REGS),
    localparam int AW = $clog2(NUM_ARCH_REGS + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [COMMIT_WIDTH-1:0]                commit_valid,
    input  logic [COMMIT_WIDTH-1:0]                commit_has_dst,
    input  logic [COMMIT_WIDTH-1:0][AW-1:0]        commit_arch_dst,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]        commit_phys_dst,
    input  logic [COMMIT_WIDTH-1:0]                commit_sets_nzcv,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]        commit_phys_nzcv,
    output logic                                   commit_ready,
    output logic [FREE_OUT_WIDTH-1:0]              free_valid,
    output logic [FREE_OUT_WIDTH-1:0][PW-1:0]      free_reg,
    input  logic                                   free_ready,
    input  logic                                   recover_req,
    output logic                                   recover_valid,
    output logic [RECOVER_WIDTH-1:0][AW-1:0]       recover_idx,
    output logic [RECOVER_WIDTH-1:0]               recover_mask,
    output logic [RECOVER_WIDTH-1:0][PW-1:0]       recover_phys,
    output logic                                   recover_done,
    output logic                                   busy
);

    localparam int NUM_ENT   = NUM_ARCH_REGS + 1;
    localparam int NZCV_IDX  = NUM_ARCH_REGS;
    localparam int MAX_PUSH  = 2 * COMMIT_WIDTH;
    localparam int QW        = (FREE_Q_DEPTH > 1) ? $clog2(FREE_Q_DEPTH) : 1;
    localparam int CNTW      = $clog2(FREE_Q_DEPTH + 1);
    localparam int NUM_BEATS = (NUM_ENT + RECOVER_WIDTH - 1) / RECOVER_WIDTH;
    localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [PW-1:0]   map_q     [NUM_ENT];
    logic [PW-1:0]   map_d     [NUM_ENT];
    logic [PW-1:0]   push_data [MAX_PUSH];
    logic [PW-1:0]   fifo_mem  [FREE_Q_DEPTH];
    logic [QW-1:0]   rd_q, wr_q;
    logic [CNTW-1:0] count_q, push_cnt, push_eff, pop_cnt;
    logic [1:0]      state_q, state_d;
    logic [BW-1:0]   beat_q;
    int              n;

    function automatic logic [QW-1:0] q_add(input logic [QW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= FREE_Q_DEPTH) s = s - FREE_Q_DEPTH;
        return QW'(s);
    endfunction

    assign commit_ready = (state_q == S_IDLE) &&
                          ((CNTW'(FREE_Q_DEPTH) - count_q) >= CNTW'(MAX_PUSH)) &&
                          !recover_req;

    // Lanes resolved serially so a later lane sees (and frees) an earlier lane's mapping.
    always_comb begin
        map_d = map_q;
        n = 0;
        for (int p = 0; p < MAX_PUSH; p++) push_data[p] = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_valid[i]) begin
                if (commit_has_dst[i]) begin
                    if (map_d[commit_arch_dst[i]] != commit_phys_dst[i]) begin
                        push_data[n] = map_d[commit_arch_dst[i]];
                        n = n + 1;
                    end
                    map_d[commit_arch_dst[i]] = commit_phys_dst[i];
                end
                if (commit_sets_nzcv[i]) begin
                    if (map_d[NZCV_IDX] != commit_phys_nzcv[i]) begin
                        push_data[n] = map_d[NZCV_IDX];
                        n = n + 1;
                    end
                    map_d[NZCV_IDX] = commit_phys_nzcv[i];
                end
            end
        end
    end

    assign push_cnt = CNTW'(n);
    assign push_eff = commit_ready ? push_cnt : '0;
    assign pop_cnt  = !free_ready ? '0 :
                      (count_q >= CNTW'(FREE_OUT_WIDTH)) ? CNTW'(FREE_OUT_WIDTH) : count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENT; i++) map_q[i] <= PW'(i);
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (commit_ready) map_q <= map_d;
            wr_q    <= q_add(wr_q, int'(push_eff));
            rd_q    <= q_add(rd_q, int'(pop_cnt));
            count_q <= count_q + push_eff - pop_cnt;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int p = 0; p < MAX_PUSH; p++) begin
            if (commit_ready && (p < int'(push_cnt))) fifo_mem[q_add(wr_q, p)] <= push_data[p];
        end
    end

    always_comb begin
        for (int k = 0; k < FREE_OUT_WIDTH; k++) begin
            free_valid[k] = 1'b0;
            free_reg[k]   = '0;
            if (int'(count_q) > k) begin
                free_valid[k] = 1'b1;
                free_reg[k]   = fifo_mem[q_add(rd_q, k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= (state_q == S_STREAM && state_d == S_STREAM) ? beat_q + BW'(1) : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (recover_req) state_d = S_STREAM;
            S_STREAM: if (beat_q == BW'(NUM_BEATS - 1)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        int e;
        recover_valid = (state_q == S_STREAM);
        recover_done  = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
        for (int j = 0; j < RECOVER_WIDTH; j++) begin
            e = int'(beat_q) * RECOVER_WIDTH + j;
            recover_idx[j]  = '0;
            recover_mask[j] = 1'b0;
            recover_phys[j] = '0;
            if (recover_valid) begin
                recover_idx[j] = AW'(e);
                if (e < NUM_ENT) begin
                    recover_mask[j] = 1'b1;
                    recover_phys[j] = map_q[e];
                end
            end
        end
    end

endmodule

`default_nettype wire
